// File: rtl/decoder_pkg.sv
// ============================================================================
// decoder_pkg : shared types for the decoder request path
// Rev 1.0
// ============================================================================
`default_nettype none

package decoder_pkg;

   localparam int c_dec_addr_w = 4;
   localparam int c_dec_data_w = 32;
   localparam int c_dec_len_w  = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } seq_state_t;

   typedef struct packed {
      logic [c_dec_addr_w-1:0] addr;
      logic [c_dec_data_w-1:0] data;
      logic [c_dec_len_w-1:0]  len;
   } dec_req_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : generic single-clock FIFO, head visible combinationally on rdata
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign full      = (r_count == c_cnt_w'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign rdata     = r_mem[r_rd_ptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // Storage carries no reset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + c_cnt_w'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - c_cnt_w'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/decoder_req_sequencer.sv
// ============================================================================
// decoder_req_sequencer : queues write requests and expands each into
// single-cycle decoder beats, one per cycle, holding on dec_stall.
// Rev 1.0
// ============================================================================
`default_nettype none

module decoder_req_sequencer
   import decoder_pkg::*;
#(
   parameter int ADDR_W     = c_dec_addr_w,
   parameter int DATA_W     = c_dec_data_w,
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = c_dec_len_w
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic [DATA_W-1:0]             req_data,
   input  logic [LEN_W-1:0]              req_len,
   output logic                          dec_en,
   output logic [ADDR_W-1:0]             dec_addr,
   output logic [DATA_W-1:0]             dec_data,
   input  logic                          dec_stall,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   dec_req_t                 w_push_req;
   dec_req_t                 w_head;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_full;
   logic                     w_empty;

   seq_state_t               r_state;
   seq_state_t               w_state_nxt;
   logic [ADDR_W-1:0]        r_addr;
   logic [ADDR_W-1:0]        w_addr_nxt;
   logic [DATA_W-1:0]        r_data;
   logic [DATA_W-1:0]        w_data_nxt;
   logic [LEN_W-1:0]         r_rem;
   logic [LEN_W-1:0]         w_rem_nxt;

   assign w_push_req = '{addr: req_addr, data: req_data, len: req_len};
   assign req_ready  = !w_full && !rst;
   assign w_push     = req_valid && req_ready;

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(dec_req_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (w_push_req),
      .rdata (w_head),
      .count (fifo_count),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_data  <= '0;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_data  <= w_data_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   // Popping on the final accepted beat keeps back-to-back requests bubble-free.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      w_rem_nxt   = r_rem;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_addr_nxt  = w_head.addr;
               w_data_nxt  = w_head.data;
               w_rem_nxt   = w_head.len;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (!dec_stall) begin
               if (r_rem != '0) begin
                  w_addr_nxt = r_addr + ADDR_W'(1);
                  w_rem_nxt  = r_rem - LEN_W'(1);
               end else if (!w_empty) begin
                  w_pop      = 1'b1;
                  w_addr_nxt = w_head.addr;
                  w_data_nxt = w_head.data;
                  w_rem_nxt  = w_head.len;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign dec_en   = (r_state == ISSUE);
   assign dec_addr = r_addr;
   assign dec_data = r_data;
   assign busy     = (r_state == ISSUE) || (fifo_count != '0);

endmodule

`default_nettype wire
